// File: rtl/riscv_pkg.sv
// Shared definitions for the pipelined core: datapath widths, ALU opcodes
// and the operand-forwarding select encoding.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_MEM  = 2'd1,
        FWD_WB   = 2'd2
    } fwd_sel_e;

endpackage

// File: rtl/forward_mux.sv
// Per-operand forwarding: picks EX/MEM over MEM/WB over the registered value;
// x0 is never forwarded.
module forward_mux #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs_i,
    input  logic [XLEN-1:0]       reg_val_i,
    input  logic [REG_ADDR_W-1:0] mem_rd_i,
    input  logic                  mem_reg_write_i,
    input  logic [XLEN-1:0]       mem_result_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_i,
    input  logic                  wb_reg_write_i,
    input  logic [XLEN-1:0]       wb_result_i,
    output riscv_pkg::fwd_sel_e   sel_o,
    output logic [XLEN-1:0]       val_o
);
    import riscv_pkg::*;

    logic rs_nonzero;

    assign rs_nonzero = (rs_i != '0);

    always_comb begin
        sel_o = FWD_NONE;
        if (mem_reg_write_i && (mem_rd_i == rs_i) && rs_nonzero) begin
            sel_o = FWD_MEM;
        end else if (wb_reg_write_i && (wb_rd_i == rs_i) && rs_nonzero) begin
            sel_o = FWD_WB;
        end
    end

    always_comb begin
        val_o = reg_val_i;
        case (sel_o)
            FWD_MEM: val_o = mem_result_i;
            FWD_WB:  val_o = wb_result_i;
            default: val_o = reg_val_i;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with capture bypass, load-use bubble insertion,
// branch flush and EX-stage operand forwarding into the ALU.
module id_ex_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    output logic                  id_ready,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [XLEN-1:0]       id_rs1_data,
    input  logic [XLEN-1:0]       id_rs2_data,
    input  logic [XLEN-1:0]       id_imm,
    input  logic                  id_alu_src,
    input  logic [2:0]            id_alu_control,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  flush,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_reg_write,
    input  logic [XLEN-1:0]       mem_result,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  wb_reg_write,
    input  logic [XLEN-1:0]       wb_result,
    output logic                  ex_valid,
    output logic [XLEN-1:0]       ex_A,
    output logic [XLEN-1:0]       ex_B,
    output logic [2:0]            ex_alu_control,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic [XLEN-1:0]       ex_store_data
);
    import riscv_pkg::*;

    logic                  valid_q;
    logic [REG_ADDR_W-1:0] rs1_q, rs2_q, rd_q;
    logic [XLEN-1:0]       rs1_val_q, rs2_val_q, imm_q;
    logic                  alu_src_q;
    logic [2:0]            alu_control_q;
    logic                  reg_write_q, mem_read_q, mem_write_q;

    logic [XLEN-1:0]       rs1_val_d, rs2_val_d;
    logic                  rs2_used, hazard;
    logic [XLEN-1:0]       rs1_fwd, rs2_fwd;
    fwd_sel_e              rs1_sel, rs2_sel;
    logic                  unused_fwd_sel;

    // The register file writes this same edge, so its read data is still stale.
    always_comb begin
        rs1_val_d = id_rs1_data;
        rs2_val_d = id_rs2_data;
        if (wb_reg_write && (wb_rd == id_rs1) && (id_rs1 != '0)) rs1_val_d = wb_result;
        if (wb_reg_write && (wb_rd == id_rs2) && (id_rs2 != '0)) rs2_val_d = wb_result;
    end

    assign rs2_used = ~id_alu_src | id_mem_write;
    assign hazard   = id_valid & ex_valid & ex_mem_read & (rd_q != '0) &
                      ((rd_q == id_rs1) | ((rd_q == id_rs2) & rs2_used));
    assign id_ready = ~hazard;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q       <= 1'b0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            rd_q          <= '0;
            rs1_val_q     <= '0;
            rs2_val_q     <= '0;
            imm_q         <= '0;
            alu_src_q     <= 1'b0;
            alu_control_q <= '0;
            reg_write_q   <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
        end else if (flush || hazard) begin
            valid_q <= 1'b0;
        end else begin
            valid_q       <= id_valid;
            rs1_q         <= id_rs1;
            rs2_q         <= id_rs2;
            rd_q          <= id_rd;
            rs1_val_q     <= rs1_val_d;
            rs2_val_q     <= rs2_val_d;
            imm_q         <= id_imm;
            alu_src_q     <= id_alu_src;
            alu_control_q <= id_alu_control;
            reg_write_q   <= id_reg_write;
            mem_read_q    <= id_mem_read;
            mem_write_q   <= id_mem_write;
        end
    end

    forward_mux #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
        .rs_i(rs1_q), .reg_val_i(rs1_val_q),
        .mem_rd_i(mem_rd), .mem_reg_write_i(mem_reg_write), .mem_result_i(mem_result),
        .wb_rd_i(wb_rd), .wb_reg_write_i(wb_reg_write), .wb_result_i(wb_result),
        .sel_o(rs1_sel), .val_o(rs1_fwd)
    );

    forward_mux #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
        .rs_i(rs2_q), .reg_val_i(rs2_val_q),
        .mem_rd_i(mem_rd), .mem_reg_write_i(mem_reg_write), .mem_result_i(mem_result),
        .wb_rd_i(wb_rd), .wb_reg_write_i(wb_reg_write), .wb_result_i(wb_result),
        .sel_o(rs2_sel), .val_o(rs2_fwd)
    );

    // Selects are only needed for debug visibility at this level.
    assign unused_fwd_sel = ^{rs1_sel, rs2_sel};

    assign ex_valid       = valid_q;
    assign ex_A           = rs1_fwd;
    assign ex_B           = alu_src_q ? imm_q : rs2_fwd;
    assign ex_store_data  = rs2_fwd;
    assign ex_alu_control = alu_control_q;
    assign ex_rd          = rd_q;
    assign ex_reg_write   = valid_q & reg_write_q;
    assign ex_mem_read    = valid_q & mem_read_q;
    assign ex_mem_write   = valid_q & mem_write_q;

endmodule
